// File: rtl/mure_pkg.sv
// Shared types for the trace-side instruction-type detectors.
package mure_pkg;

  localparam int ITYPE_LEN = 3;

  typedef enum logic [ITYPE_LEN-1:0] {
    STD  = 3'd0,
    EXC  = 3'd1,
    INT  = 3'd2,
    ERET = 3'd3,
    NTB  = 3'd4,
    TB   = 3'd5,
    UIJ  = 3'd6
  } itype_e;

  typedef enum logic [2:0] {
    NoCF   = 3'd0,
    Branch = 3'd1,
    Jump   = 3'd2,
    JumpR  = 3'd3,
    Return = 3'd4
  } cf_t;

  typedef enum logic [1:0] {
    KTB  = 2'd0,
    KNTB = 2'd1,
    KUIJ = 2'd2
  } bkind_e;

  function automatic itype_e kind_to_itype(input bkind_e kind);
    case (kind)
      KTB:     return TB;
      KNTB:    return NTB;
      KUIJ:    return UIJ;
      default: return STD;
    endcase
  endfunction

endpackage

// File: rtl/itype_detector_mp_if.sv
// Commit/resolve inputs and itype outputs of the multi-port detector.
interface itype_detector_mp_if #(
  parameter int NRET  = 2,
  parameter int XLEN  = 64,
  parameter int CNT_W = 8
) ();
  import mure_pkg::*;

  logic [NRET-1:0]           commit_valid_i;
  logic [NRET*XLEN-1:0]      commit_pc_i;
  logic [NRET-1:0]           commit_ex_i;
  logic [NRET-1:0]           interrupt_i;
  logic [NRET-1:0]           eret_i;
  logic                      resolve_valid_i;
  cf_t                       resolve_type_i;
  logic                      resolve_taken_i;
  logic [XLEN-1:0]           resolve_pc_i;
  logic [NRET-1:0]           itype_valid_o;
  logic [NRET*ITYPE_LEN-1:0] itype_o;
  logic [CNT_W-1:0]          evict_cnt_o;

  modport master (
    output commit_valid_i, commit_pc_i, commit_ex_i, interrupt_i, eret_i,
    output resolve_valid_i, resolve_type_i, resolve_taken_i, resolve_pc_i,
    input  itype_valid_o, itype_o, evict_cnt_o
  );

  modport slave (
    input  commit_valid_i, commit_pc_i, commit_ex_i, interrupt_i, eret_i,
    input  resolve_valid_i, resolve_type_i, resolve_taken_i, resolve_pc_i,
    output itype_valid_o, itype_o, evict_cnt_o
  );
endinterface

// File: rtl/itype_branch_buf.sv
// Associative buffer of resolved branch outcomes with per-port lookup and consume.
module itype_branch_buf
  import mure_pkg::*;
#(
  parameter int NRET      = 2,
  parameter int XLEN      = 64,
  parameter int BUF_DEPTH = 4,
  parameter int CNT_W     = 8
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            resolve_valid_i,
  input  cf_t             resolve_type_i,
  input  logic            resolve_taken_i,
  input  logic [XLEN-1:0] resolve_pc_i,
  input  logic [XLEN-1:0] lookup_pc_i [NRET],
  input  logic [NRET-1:0] consume_i,
  output logic [NRET-1:0] hit_o,
  output bkind_e          kind_o [NRET],
  output logic [CNT_W-1:0] evict_cnt_o
);
  localparam int IDX_W = $clog2(BUF_DEPTH);

  logic [BUF_DEPTH-1:0] valid_reg;
  logic [XLEN-1:0]      pc_reg [BUF_DEPTH];
  bkind_e               kind_reg [BUF_DEPTH];
  logic [IDX_W-1:0]     wr_ptr_reg;
  logic [CNT_W-1:0]     evict_cnt_reg;

  logic                 wr_en, wr_match, fwd_drop, alloc;
  bkind_e               wr_kind;
  logic [IDX_W-1:0]     wr_idx;
  logic [NRET-1:0]      fwd;
  logic [BUF_DEPTH-1:0] clear;

  always_comb begin
    wr_en    = resolve_valid_i && (resolve_type_i == Branch || resolve_type_i == JumpR);
    wr_kind  = (resolve_type_i == JumpR) ? KUIJ : (resolve_taken_i ? KTB : KNTB);
    wr_match = 1'b0;
    wr_idx   = '0;
    for (int i = 0; i < BUF_DEPTH; i++) begin
      if (valid_reg[i] && pc_reg[i] == resolve_pc_i) begin
        wr_match = 1'b1;
        wr_idx   = IDX_W'(i);
      end
    end
  end

  // The same-cycle resolve takes precedence over any stored entry.
  always_comb begin
    fwd_drop = 1'b0;
    for (int k = 0; k < NRET; k++) begin
      fwd[k]    = wr_en && (lookup_pc_i[k] == resolve_pc_i);
      hit_o[k]  = fwd[k];
      kind_o[k] = wr_kind;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        if (!fwd[k] && valid_reg[i] && pc_reg[i] == lookup_pc_i[k]) begin
          hit_o[k]  = 1'b1;
          kind_o[k] = kind_reg[i];
        end
      end
      if (consume_i[k] && fwd[k]) fwd_drop = 1'b1;
    end
    // A fresh outcome consumed in its own resolve cycle is never stored.
    alloc = wr_en && !wr_match && !fwd_drop;
  end

  always_comb begin
    clear = '0;
    for (int i = 0; i < BUF_DEPTH; i++)
      for (int k = 0; k < NRET; k++)
        if (consume_i[k] && valid_reg[i] && pc_reg[i] == lookup_pc_i[k]) clear[i] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_reg     <= '0;
      wr_ptr_reg    <= '0;
      evict_cnt_reg <= '0;
    end else begin
      valid_reg <= valid_reg & ~clear;
      if (wr_en && wr_match) valid_reg[wr_idx] <= 1'b1;
      if (alloc) begin
        valid_reg[wr_ptr_reg] <= 1'b1;
        wr_ptr_reg            <= wr_ptr_reg + 1'b1;
        if (valid_reg[wr_ptr_reg] && evict_cnt_reg != '1)
          evict_cnt_reg <= evict_cnt_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en && wr_match) kind_reg[wr_idx] <= wr_kind;
    if (alloc) begin
      pc_reg[wr_ptr_reg]   <= resolve_pc_i;
      kind_reg[wr_ptr_reg] <= wr_kind;
    end
  end

  assign evict_cnt_o = evict_cnt_reg;

endmodule

// File: rtl/itype_detector_mp.sv
// Multi-port instruction-type detector: priority encoding, flush and output registers.
module itype_detector_mp
  import mure_pkg::*;
#(
  parameter int NRET      = 2,
  parameter int XLEN      = 64,
  parameter int BUF_DEPTH = 4,
  parameter int CNT_W     = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  itype_detector_mp_if.slave bus
);
  logic [XLEN-1:0]           pc_a [NRET];
  logic [NRET-1:0]           buf_hit, consume;
  bkind_e                    buf_kind [NRET];
  logic [NRET-1:0]           itype_valid_next, itype_valid_reg;
  logic [NRET*ITYPE_LEN-1:0] itype_next, itype_reg;

  generate
    for (genvar gi = 0; gi < NRET; gi++) begin : g_pc
      assign pc_a[gi] = bus.commit_pc_i[gi*XLEN +: XLEN];
    end
  endgenerate

  itype_branch_buf #(
    .NRET(NRET), .XLEN(XLEN), .BUF_DEPTH(BUF_DEPTH), .CNT_W(CNT_W)
  ) u_buf (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .resolve_valid_i (bus.resolve_valid_i),
    .resolve_type_i  (bus.resolve_type_i),
    .resolve_taken_i (bus.resolve_taken_i),
    .resolve_pc_i    (bus.resolve_pc_i),
    .lookup_pc_i     (pc_a),
    .consume_i       (consume),
    .hit_o           (buf_hit),
    .kind_o          (buf_kind),
    .evict_cnt_o     (bus.evict_cnt_o)
  );

  // Ports are walked oldest first; EXC/INT squash every younger port.
  always_comb begin : p_prio
    logic   flush;
    logic   hit;
    itype_e itype_k;
    flush            = 1'b0;
    consume          = '0;
    itype_valid_next = '0;
    itype_next       = '0;
    for (int k = 0; k < NRET; k++) begin
      hit     = 1'b0;
      itype_k = STD;
      if (bus.commit_valid_i[k] && !flush) begin
        hit = buf_hit[k] && (pc_a[k] != '0);
        for (int j = 0; j < k; j++)
          if (consume[j] && pc_a[j] == pc_a[k]) hit = 1'b0;
        consume[k]          = hit;
        itype_valid_next[k] = 1'b1;
        if (bus.commit_ex_i[k]) begin
          itype_k = EXC;
          flush   = 1'b1;
        end else if (bus.interrupt_i[k]) begin
          itype_k = INT;
          flush   = 1'b1;
        end else if (bus.eret_i[k]) begin
          itype_k = ERET;
        end else if (hit) begin
          itype_k = kind_to_itype(buf_kind[k]);
        end
      end
      itype_next[k*ITYPE_LEN +: ITYPE_LEN] = itype_k;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      itype_valid_reg <= '0;
      itype_reg       <= '0;
    end else begin
      itype_valid_reg <= itype_valid_next;
      itype_reg       <= itype_next;
    end
  end

  assign bus.itype_valid_o = itype_valid_reg;
  assign bus.itype_o       = itype_reg;

endmodule

// File: tb/tb_itype_detector_mp.sv
// Directed and randomized check of itype_detector_mp against a behavioural outcome-table model.
module tb_itype_detector_mp;
  import mure_pkg::*;

  localparam int NRET  = 2;
  localparam int XLEN  = 64;
  localparam int DEPTH = 4;
  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  itype_detector_mp_if #(.NRET(NRET), .XLEN(XLEN), .CNT_W(CNT_W)) bus ();

  itype_detector_mp #(.NRET(NRET), .XLEN(XLEN), .BUF_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // stimulus variables
  logic [NRET-1:0] c_valid, c_ex, c_int, c_eret;
  logic [63:0]     c_pc [NRET];
  logic            r_valid, r_taken;
  int              r_type;
  logic [63:0]     r_pc;

  // reference outcome table
  bit          m_v    [DEPTH];
  logic [63:0] m_pc   [DEPTH];
  int          m_kind [DEPTH];
  int          m_ptr, m_cnt;

  int n_vec = 0;
  int n_err = 0;

  function automatic int find(input logic [63:0] p);
    for (int i = 0; i < DEPTH; i++) if (m_v[i] && m_pc[i] == p) return i;
    return -1;
  endfunction

  function automatic int kind_itype(input int kd);
    return (kd == 0) ? 5 : (kd == 1) ? 4 : 6;  // taken->TB, not-taken->NTB, jumpr->UIJ
  endfunction

  task automatic model_step(output logic [NRET-1:0] ev, output logic [NRET*3-1:0] ei);
    logic [63:0] consumed [$];
    bit  pre_v [DEPTH];
    bit  flush, wr, vis, hit, dup;
    int  wk, vk, slot, s, it;
    ev = '0;
    ei = '0;
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) m_v[i] = 0;
      m_ptr = 0;
      m_cnt = 0;
      return;
    end
    flush = 0;
    wr = r_valid && (r_type == 1 || r_type == 3);
    wk = (r_type == 3) ? 2 : (r_taken ? 0 : 1);
    for (int k = 0; k < NRET; k++) begin
      if (!c_valid[k] || flush) continue;
      ev[k] = 1'b1;
      vis = 0; vk = 0;
      if (wr && r_pc == c_pc[k]) begin vis = 1; vk = wk; end
      else if (find(c_pc[k]) >= 0) begin vis = 1; vk = m_kind[find(c_pc[k])]; end
      dup = 0;
      foreach (consumed[q]) if (consumed[q] == c_pc[k]) dup = 1;
      hit = vis && (c_pc[k] != 0) && !dup;
      if (hit) consumed.push_back(c_pc[k]);
      if (c_ex[k])        begin it = 1; flush = 1; end
      else if (c_int[k])  begin it = 2; flush = 1; end
      else if (c_eret[k]) it = 3;
      else if (hit)       it = kind_itype(vk);
      else                it = 0;
      ei[k*3 +: 3] = 3'(it);
    end
    for (int i = 0; i < DEPTH; i++) pre_v[i] = m_v[i];
    slot = wr ? find(r_pc) : -1;
    foreach (consumed[q]) begin
      s = find(consumed[q]);
      if (s >= 0) m_v[s] = 0;
    end
    if (wr) begin
      dup = 0;
      foreach (consumed[q]) if (consumed[q] == r_pc) dup = 1;
      if (slot >= 0) begin
        m_v[slot] = 1; m_kind[slot] = wk;
      end else if (!dup) begin
        if (pre_v[m_ptr] && m_cnt < 255) m_cnt++;
        m_v[m_ptr] = 1; m_pc[m_ptr] = r_pc; m_kind[m_ptr] = wk;
        m_ptr = (m_ptr + 1) % DEPTH;
      end
    end
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic idle();
    c_valid = '0; c_ex = '0; c_int = '0; c_eret = '0;
    for (int k = 0; k < NRET; k++) c_pc[k] = '0;
    r_valid = 0; r_taken = 0; r_type = 0; r_pc = '0;
  endtask

  // Drive, step the model, clock, then compare one cycle later.
  task automatic tick();
    logic [NRET-1:0]   ev;
    logic [NRET*3-1:0] ei;
    int                cnt_exp;
    bus.commit_valid_i  = c_valid;
    bus.commit_ex_i     = c_ex;
    bus.interrupt_i     = c_int;
    bus.eret_i          = c_eret;
    for (int k = 0; k < NRET; k++) bus.commit_pc_i[k*XLEN +: XLEN] = c_pc[k];
    bus.resolve_valid_i = r_valid;
    bus.resolve_type_i  = cf_t'(r_type[2:0]);
    bus.resolve_taken_i = r_taken;
    bus.resolve_pc_i    = r_pc;
    model_step(ev, ei);
    cnt_exp = m_cnt;
    @(posedge clk);
    #1;
    check("itype_valid", 64'(bus.itype_valid_o), 64'(ev));
    check("itype",       64'(bus.itype_o),       64'(ei));
    check("evict_cnt",   64'(bus.evict_cnt_o),   64'(cnt_exp));
    $display("cyc t=%0t valid=%b itype=%h evict=%0d", $time, bus.itype_valid_o, bus.itype_o, bus.evict_cnt_o);
  endtask

  initial begin
    idle();
    rst = 1;
    tick(); tick();
    check("reset_valid", 64'(bus.itype_valid_o), 64'd0);
    check("reset_evict", 64'(bus.evict_cnt_o), 64'd0);
    rst = 0;

    // 1: taken branch, then commit, then recommit
    idle(); r_valid = 1; r_type = 1; r_taken = 1; r_pc = 64'h1000; tick();
    idle(); c_valid = 2'b01; c_pc[0] = 64'h1000; tick();
    check("t1_tb", 64'(bus.itype_o[2:0]), 64'd5);
    check("t1_valid", 64'(bus.itype_valid_o), 64'd1);
    tick();
    check("t1_consumed", 64'(bus.itype_o[2:0]), 64'd0);

    // 2: forwarding of a same-cycle JumpR
    idle(); r_valid = 1; r_type = 3; r_pc = 64'h2000; c_valid = 2'b10; c_pc[1] = 64'h2000; tick();
    check("t2_uij", 64'(bus.itype_o[5:3]), 64'd6);
    idle(); c_valid = 2'b10; c_pc[1] = 64'h2000; tick();
    check("t2_gone", 64'(bus.itype_o[5:3]), 64'd0);

    // 3: exception flushes port1, whose entry survives
    idle(); r_valid = 1; r_type = 1; r_taken = 0; r_pc = 64'h3004; tick();
    idle(); c_valid = 2'b11; c_ex = 2'b01; c_pc[0] = 64'h3000; c_pc[1] = 64'h3004; tick();
    check("t3_exc", 64'(bus.itype_o[2:0]), 64'd1);
    check("t3_flush", 64'(bus.itype_valid_o), 64'd1);
    idle(); c_valid = 2'b01; c_pc[0] = 64'h3004; tick();
    check("t3_ntb", 64'(bus.itype_o[2:0]), 64'd4);

    // 4: five distinct branches into four slots
    for (int i = 1; i <= 5; i++) begin
      idle(); r_valid = 1; r_type = 1; r_taken = 1; r_pc = 64'(i * 16); tick();
    end
    check("t4_evict", 64'(bus.evict_cnt_o), 64'd1);
    idle(); c_valid = 2'b01; c_pc[0] = 64'h10; tick();
    check("t4_evicted", 64'(bus.itype_o[2:0]), 64'd0);
    idle(); c_valid = 2'b01; c_pc[0] = 64'h50; tick();
    check("t4_newest", 64'(bus.itype_o[2:0]), 64'd5);
    idle(); r_valid = 1; r_type = 1; r_taken = 0; r_pc = 64'h20; tick();
    check("t4_inplace", 64'(bus.evict_cnt_o), 64'd1);

    // 5: two ports on one entry
    idle(); r_valid = 1; r_type = 1; r_taken = 0; r_pc = 64'h4000; tick();
    idle(); c_valid = 2'b11; c_pc[0] = 64'h4000; c_pc[1] = 64'h4000; tick();
    check("t5_p0", 64'(bus.itype_o[2:0]), 64'd4);
    check("t5_p1", 64'(bus.itype_o[5:3]), 64'd0);

    // 6: reset mid-stream
    idle(); r_valid = 1; r_type = 1; r_taken = 1; r_pc = 64'h5000; tick();
    idle(); rst = 1; c_valid = 2'b11; c_pc[0] = 64'h5000; c_pc[1] = 64'h3004;
    r_valid = 1; r_type = 3; r_pc = 64'h6000; tick();
    check("t6_valid", 64'(bus.itype_valid_o), 64'd0);
    check("t6_evict", 64'(bus.evict_cnt_o), 64'd0);
    rst = 0;
    idle(); c_valid = 2'b01; c_pc[0] = 64'h5000; tick();
    check("t6_miss", 64'(bus.itype_o[2:0]), 64'd0);

    // randomized traffic over a small PC pool to force collisions
    for (int n = 0; n < 3000; n++) begin
      idle();
      rst = ($urandom_range(0, 149) == 0);
      for (int k = 0; k < NRET; k++) begin
        c_valid[k] = $urandom_range(0, 3) != 0;
        c_ex[k]    = $urandom_range(0, 7) == 0;
        c_int[k]   = $urandom_range(0, 7) == 0;
        c_eret[k]  = $urandom_range(0, 7) == 0;
        c_pc[k]    = 64'($urandom_range(0, 7)) << 4;
      end
      r_valid = $urandom_range(0, 1) == 1;
      r_type  = $urandom_range(0, 4);
      r_taken = $urandom_range(0, 1) == 1;
      r_pc    = 64'($urandom_range(0, 7)) << 4;
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/itype_detector_mp.md
Name: itype_detector_mp

Overview:
- Multi-port, parametrised successor to the single-port instruction-type detector. Sits between the core commit stage and the trace encoder.
- A small associative buffer records resolved branch/jump outcomes. Each cycle, up to NRET committed instructions are matched against it, producing a registered itype per commit port.
- Adds multi-retire support, a configurable outcome-buffer depth with entry consumption and eviction counting, and flushing of younger ports after an exception.

Parameters:
- NRET, 2, number of commit ports (1..4).
- XLEN, 64, PC width.
- BUF_DEPTH, 4, resolved-outcome buffer entries (power of two, 2..16).
- CNT_W, 8, width of the saturating eviction counter.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset (one clock; reset is synchronous and active-high).
- commit_valid_i  in  NRET  per-port commit valid; port 0 is the oldest.
- commit_pc_i  in  NRET*XLEN  per-port committed PC.
- commit_ex_i  in  NRET  per-port exception flag.
- interrupt_i  in  NRET  per-port interrupt taken.
- eret_i  in  NRET  per-port exception return.
- resolve_valid_i  in  1  branch-resolution event.
- resolve_type_i  in  cf_t  Branch / JumpR / other.
- resolve_taken_i  in  1  taken flag (Branch only).
- resolve_pc_i  in  XLEN  PC of the resolved instruction.
- itype_valid_o  out  NRET  registered per-port valid.
- itype_o  out  NRET*itype_e  registered per-port itype.
- evict_cnt_o  out  CNT_W  saturating count of live entries overwritten.

Behaviour:
- Reset: all buffer entries invalid; write pointer 0; itype_valid_o = 0; itype_o = STD on every port; evict_cnt_o = 0.
- Latency: one cycle from commit inputs to outputs. Outputs are registered, and itype_valid_o[k] equals the previous cycle's effective commit_valid_i[k].

Buffer write (sub-module):
- An entry is {valid, pc, kind}, with kind in {KTB, KNTB, KUIJ}.
- On resolve_valid_i:
  - Branch & taken → KTB.
  - Branch & !taken → KNTB.
  - JumpR → KUIJ.
  - Any other type → no write.
- If a valid entry has an equal pc, it is overwritten in place and the pointer is not advanced.
- Otherwise the entry at the write pointer is written and the pointer increments modulo BUF_DEPTH. If that slot was valid, evict_cnt_o increments, saturating at all-ones.

Lookup:
- Port k hits when commit_valid_i[k] is set, commit_pc_i[k] != 0, and a valid entry's pc equals commit_pc_i[k].
- The same-cycle resolve is forwarded: a lookup matching resolve_pc_i sees the new kind.
- A hit consumes the entry: valid is cleared at the clock edge, unless the same cycle also rewrites that pc, in which case the write wins.
- Two ports hitting the same entry: the lowest port consumes it; higher ports see a miss (STD).

Priority per port:
- EXC (commit_valid & commit_ex) > INT > ERET > NTB > TB > UIJ > STD.

Flush:
- If port k yields EXC or INT, ports j>k produce itype_valid_o[j] = 0 and itype_o[j] = STD, and they consume no entries.

Other rules:
- When commit_valid_i[k] = 0: itype_valid_o[k] = 0 and itype_o[k] = STD; interrupt_i[k] and eret_i[k] are ignored.
- A reset asserted mid-stream overrides every concurrent write and consume.
- PC comparison uses full XLEN equality; there is no wrap or truncation.

Decomposition:
- Shared package mure_pkg gains or holds: itype_e (STD, EXC, INT, ERET, NTB, TB, UIJ), cf_t, bkind_e {KTB, KNTB, KUIJ}, ITYPE_LEN.
- Sub-module itype_branch_buf holds the entries, write pointer, eviction counter and consume logic. It exposes NRET combinational match ports (hit, kind) plus NRET consume strobes.
- The top level holds the priority encoding, flush logic and output registers.

Test Plan:
1. Resolve Branch taken at PC 0x1000; next cycle commit port0 PC 0x1000 → one cycle later itype_o[0]=TB, valid=1. Recommit of 0x1000 → STD (entry consumed).
2. Same cycle: resolve JumpR at 0x2000 and commit port1 at 0x2000 → itype_o[1]=UIJ via forwarding; buffer holds no valid entry for 0x2000 afterwards.
3. Port0 exception at PC 0x3000, port1 at PC 0x3004 with a pending NTB entry → itype_o[0]=EXC, itype_valid_o[1]=0, and the 0x3004 entry is still present (a later commit yields NTB).
4. BUF_DEPTH=4: resolve 5 distinct branches 0x10..0x50 → evict_cnt_o=1, commit of 0x10 → STD, commit of 0x50 → matching kind. Re-resolve an existing pc → evict_cnt_o unchanged.
5. Both ports commit PC 0x4000 with one NTB entry → port0 NTB, port1 STD.
6. Assert rst_i while entries are valid and commits are active → next cycle all outputs STD/0, evict_cnt_o=0, prior entries no longer hit.
